// File: rtl/bf16_minmax_reduce.sv
// Streaming BF16 min/max reduction with argmin/argmax index and sNaN/empty flags.
// LANES elements per beat pass through a registered compare tree, then a registered accumulator.
module bf16_minmax_reduce #(
    parameter int unsigned LANES = 4,
    parameter int unsigned LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  op_max,
    input  logic [LEN_W-1:0]      len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*LANES-1:0]   in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [15:0]           out_result,
    output logic [LEN_W-1:0]      out_index,
    output logic                  out_nv,
    output logic                  out_empty
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    typedef struct packed {
        logic             vld;
        logic [15:0]      val;
        logic [LEN_W-1:0] idx;
    } cand_t;

    // Monotonic unsigned key: -0 sorts below +0, subnormals and infinities in natural order.
    function automatic logic [15:0] order_key(input logic [15:0] x);
        return x[15] ? ~x : (x | 16'h8000);
    endfunction

    // a holds the lower element indices, so it wins ties.
    function automatic cand_t pick(input cand_t a, input cand_t b, input logic use_max);
        logic [15:0] ka;
        logic [15:0] kb;
        logic        b_better;
        ka       = order_key(a.val);
        kb       = order_key(b.val);
        b_better = use_max ? (kb > ka) : (kb < ka);
        if (!b.vld) return a;
        if (!a.vld) return b;
        return b_better ? b : a;
    endfunction

    state_t           state, state_nx;
    logic [1:0]       drain_cnt;
    logic             use_max;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] elem_cnt;
    logic             accept;
    logic             last_beat;

    cand_t            node [1:2*LANES-1];
    logic [LANES-1:0] lane_nv;

    logic             s1_vld;
    cand_t            s1_cand;
    logic             s1_nv;
    cand_t            acc;
    logic             acc_nv;

    assign accept    = in_valid & in_ready;
    assign last_beat = ({1'b0, elem_cnt} + (LEN_W+1)'(LANES)) >= {1'b0, len_q};

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
            RUN:     if (accept && last_beat) state_nx = DRAIN;
            DRAIN:   if (drain_cnt == 2'd2) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        in_ready  = (state == RUN);
        out_valid = (state == DONE);
    end

    // Heap-ordered tree: node i merges children 2i (lower lanes) and 2i+1; leaves at LANES+k.
    always_comb begin
        for (int unsigned k = 0; k < LANES; k++) begin
            logic [15:0] lane;
            logic        in_range;
            logic        is_nan;
            lane     = in_data[16*k +: 16];
            in_range = ({1'b0, elem_cnt} + (LEN_W+1)'(k)) < {1'b0, len_q};
            is_nan   = (lane[14:7] == 8'hFF) && (lane[6:0] != 7'd0);
            node[LANES+k].vld = in_range && !is_nan;
            node[LANES+k].val = lane;
            node[LANES+k].idx = elem_cnt + LEN_W'(k);
            lane_nv[k]        = in_range && is_nan && !lane[6];
        end
        for (int unsigned i = LANES - 1; i >= 1; i--) begin
            node[i] = pick(node[2*i], node[2*i+1], use_max);
        end
    end

    // DONE is entered on the third edge after the last accept: tree reg, accumulate, result capture.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            use_max    <= 1'b0;
            len_q      <= '0;
            elem_cnt   <= '0;
            drain_cnt  <= '0;
            s1_vld     <= 1'b0;
            s1_cand    <= '0;
            s1_nv      <= 1'b0;
            acc        <= '0;
            acc_nv     <= 1'b0;
            out_result <= 16'h7FC0;
            out_index  <= '0;
            out_nv     <= 1'b0;
            out_empty  <= 1'b0;
        end else begin
            s1_vld    <= accept;
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (accept) begin
                s1_cand  <= node[1];
                s1_nv    <= |lane_nv;
                elem_cnt <= elem_cnt + LEN_W'(LANES);
            end
            if (s1_vld) begin
                acc    <= pick(acc, s1_cand, use_max);
                acc_nv <= acc_nv | s1_nv;
            end
            if (state == IDLE && start) begin
                use_max  <= op_max;
                len_q    <= len;
                elem_cnt <= '0;
                acc      <= '0;
                acc_nv   <= 1'b0;
                if (len == '0) begin
                    out_result <= 16'h7FC0;
                    out_index  <= '0;
                    out_nv     <= 1'b0;
                    out_empty  <= 1'b1;
                end
            end
            if (state == DRAIN && drain_cnt == 2'd2) begin
                out_result <= acc.vld ? acc.val : 16'h7FC0;
                out_index  <= acc.vld ? acc.idx : '0;
                out_nv     <= acc_nv;
                out_empty  <= !acc.vld;
            end
        end
    end
endmodule

// File: tb/tb_bf16_minmax_reduce.sv
// Self-checking bench for bf16_minmax_reduce: directed corner cases plus randomized
// vectors against a sign/magnitude reference model of minimumNumber/maximumNumber.
module tb_bf16_minmax_reduce;
    localparam int LANES = 4;
    localparam int LEN_W = 16;

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic                 op_max;
    logic [LEN_W-1:0]     len;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [16*LANES-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [15:0]          out_result;
    logic [LEN_W-1:0]     out_index;
    logic                 out_nv;
    logic                 out_empty;

    bf16_minmax_reduce #(.LANES(LANES), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op_max(op_max), .len(len),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_index(out_index), .out_nv(out_nv), .out_empty(out_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0]      elems [0:255];
    logic [15:0]      o_res;
    logic [LEN_W-1:0] o_idx;
    logic             o_nv;
    logic             o_empty;
    int               o_lat;
    bit               o_stable;
    bit               o_ok;

    logic [15:0]      m_res;
    logic [LEN_W-1:0] m_idx;
    logic             m_nv;
    logic             m_empty;

    // Strict numeric "a < b" for non-NaN BF16, by sign then magnitude.
    function automatic bit num_less(input logic [15:0] a, input logic [15:0] b);
        if (a == b) return 1'b0;
        if (a[15] != b[15]) return a[15];
        if (!a[15]) return a[14:0] < b[14:0];
        return a[14:0] > b[14:0];
    endfunction

    task automatic model(input bit op, input int n);
        int best;
        best  = -1;
        m_nv  = 1'b0;
        for (int i = 0; i < n; i++) begin
            logic [15:0] e;
            e = elems[i];
            if (e[14:7] == 8'hFF && e[6:0] != 7'd0) begin
                if (!e[6]) m_nv = 1'b1;
            end else if (best < 0) begin
                best = i;
            end else if (op ? num_less(elems[best], e) : num_less(e, elems[best])) begin
                best = i;
            end
        end
        m_empty = (best < 0);
        m_res   = (best < 0) ? 16'h7FC0 : elems[best];
        m_idx   = (best < 0) ? '0 : LEN_W'(best);
    endtask

    function automatic logic [15:0] rand_bf16();
        logic [15:0] pool [0:11];
        pool = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h7F81,
                 16'hFFC1, 16'h0001, 16'h8001, 16'h3F80, 16'hBF80, 16'hFF81};
        case ($urandom_range(3))
            0:       return 16'($urandom);
            1:       return pool[$urandom_range(11)];
            default: return {1'($urandom), 8'($urandom_range(125, 129)), 7'($urandom_range(3))};
        endcase
    endfunction

    // Drives one vector, captures the result, holds out_ready low for `hold` cycles, then accepts.
    task automatic do_vector(input bit op, input int n, input int gap_pct, input int hold);
        int nbeats;
        int waited;
        int c;
        o_ok = 1'b1; o_stable = 1'b1; o_lat = -1;
        @(negedge clk);
        start = 1'b1; op_max = op; len = LEN_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
        nbeats = (n + LANES - 1) / LANES;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            while ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            for (int k = 0; k < LANES; k++) in_data[16*k +: 16] = elems[b*LANES + k];
            waited = 0;
            while (!in_ready && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            if (!in_ready) begin
                in_valid = 1'b0;
                o_ok = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 20) begin
            @(posedge clk); #1;
            c++;
        end
        if (!out_valid) begin
            o_ok = 1'b0;
            return;
        end
        o_lat = c; o_res = out_result; o_idx = out_index; o_nv = out_nv; o_empty = out_empty;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || out_result !== o_res || out_index !== o_idx ||
                out_nv !== o_nv || out_empty !== o_empty) o_stable = 1'b0;
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        n_tests++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (out_result !== 16'h7FC0) begin n_fail++; $display("FAIL reset_result: got %h expected 7fc0", out_result); end
        n_tests++; if (out_index !== '0 || out_nv !== 1'b0 || out_empty !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got idx=%0d nv=%b empty=%b expected 0 0 0", out_index, out_nv, out_empty);
        end
    endtask

    task automatic test_min_basic();
        elems[0] = 16'h4000; elems[1] = 16'h3F80; elems[2] = 16'hC000; elems[3] = 16'h0000;
        elems[4] = 16'h0001; elems[5] = 16'h8000; elems[6] = 16'hFF81; elems[7] = 16'hFF80;
        do_vector(1'b0, 6, 0, 0);
        n_tests++; if (!o_ok) begin n_fail++; $display("FAIL min_basic_timeout: got no result expected result"); end
        n_tests++; if (o_res !== 16'hC000 || o_idx !== 16'd2) begin
            n_fail++; $display("FAIL min_basic_result: got %h@%0d expected c000@2", o_res, o_idx);
        end
        n_tests++; if (o_nv !== 1'b0 || o_empty !== 1'b0) begin
            n_fail++; $display("FAIL min_basic_flags: got nv=%b empty=%b expected 0 0 (masked lanes ignored)", o_nv, o_empty);
        end
        n_tests++; if (o_lat !== 3) begin n_fail++; $display("FAIL min_basic_latency: got %0d expected 3", o_lat); end
    endtask

    task automatic test_specials();
        elems[0] = 16'h7FC0; elems[1] = 16'h7F81; elems[2] = 16'h7F80; elems[3] = 16'h3F80;
        do_vector(1'b1, 4, 0, 0);
        n_tests++; if (o_res !== 16'h7F80 || o_idx !== 16'd2 || o_nv !== 1'b1 || o_empty !== 1'b0) begin
            n_fail++; $display("FAIL max_inf_snan: got %h@%0d nv=%b empty=%b expected 7f80@2 nv=1 empty=0", o_res, o_idx, o_nv, o_empty);
        end
        elems[0] = 16'h0000; elems[1] = 16'h8000; elems[2] = 16'h7F81; elems[3] = 16'hFF80;
        do_vector(1'b0, 2, 0, 0);
        n_tests++; if (o_res !== 16'h8000 || o_idx !== 16'd1 || o_nv !== 1'b0) begin
            n_fail++; $display("FAIL min_signed_zero: got %h@%0d nv=%b expected 8000@1 nv=0", o_res, o_idx, o_nv);
        end
        do_vector(1'b1, 2, 0, 0);
        n_tests++; if (o_res !== 16'h0000 || o_idx !== 16'd0) begin
            n_fail++; $display("FAIL max_signed_zero: got %h@%0d expected 0000@0", o_res, o_idx);
        end
    endtask

    task automatic test_empty();
        for (int i = 0; i < 4; i++) elems[i] = 16'h7FC0;
        do_vector(1'b0, 4, 0, 0);
        n_tests++; if (o_res !== 16'h7FC0 || o_idx !== 16'd0 || o_empty !== 1'b1 || o_nv !== 1'b0) begin
            n_fail++; $display("FAIL all_qnan: got %h@%0d empty=%b nv=%b expected 7fc0@0 empty=1 nv=0", o_res, o_idx, o_empty, o_nv);
        end
        do_vector(1'b1, 0, 0, 0);
        n_tests++; if (!o_ok || o_res !== 16'h7FC0 || o_idx !== 16'd0 || o_empty !== 1'b1 || o_nv !== 1'b0) begin
            n_fail++; $display("FAIL len_zero: got ok=%b %h@%0d empty=%b nv=%b expected 7fc0@0 empty=1 nv=0", o_ok, o_res, o_idx, o_empty, o_nv);
        end
        n_tests++; if (o_lat !== 0) begin n_fail++; $display("FAIL len_zero_latency: got %0d expected 0", o_lat); end
    endtask

    task automatic test_stall_ties();
        elems[0] = 16'h4000; elems[1] = 16'h3F80; elems[2] = 16'h4100; elems[3] = 16'h4040;
        elems[4] = 16'h4080; elems[5] = 16'h3F80; elems[6] = 16'h40A0; elems[7] = 16'h40C0;
        do_vector(1'b0, 8, 40, 5);
        n_tests++; if (!o_ok || o_res !== 16'h3F80 || o_idx !== 16'd1) begin
            n_fail++; $display("FAIL tie_lower_index: got ok=%b %h@%0d expected 3f80@1", o_ok, o_res, o_idx);
        end
        n_tests++; if (!o_stable) begin n_fail++; $display("FAIL done_hold_stable: got unstable expected stable outputs, in_ready=0"); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; op_max = 1'b1; len = 16'd8;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = {16'h7F81, 16'h7F80, 16'h7F80, 16'h7F80};
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        n_tests++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL midrun_reset: got busy=%b out_valid=%b in_ready=%b expected 0 0 0", busy, out_valid, in_ready);
        end
        elems[0] = 16'h3F80; elems[1] = 16'h4000; elems[2] = 16'hBF80; elems[3] = 16'h0000;
        do_vector(1'b1, 4, 0, 0);
        n_tests++; if (!o_ok || o_res !== 16'h4000 || o_idx !== 16'd1 || o_nv !== 1'b0 || o_empty !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_vector: got ok=%b %h@%0d nv=%b empty=%b expected 4000@1 nv=0 empty=0", o_ok, o_res, o_idx, o_nv, o_empty);
        end
    endtask

    task automatic test_back_to_back();
        for (int v = 0; v < 2; v++) begin
            int n;
            bit op;
            n  = $urandom_range(1, 12);
            op = 1'($urandom);
            for (int i = 0; i < n + LANES; i++) elems[i] = rand_bf16();
            model(op, n);
            do_vector(op, n, 0, 0);
            n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after_ack: got busy=%b expected 0", busy); end
            n_tests++; if (!o_ok || o_res !== m_res || o_idx !== m_idx || o_nv !== m_nv || o_empty !== m_empty) begin
                n_fail++; $display("FAIL b2b_result: got %h@%0d nv=%b empty=%b expected %h@%0d nv=%b empty=%b",
                                   o_res, o_idx, o_nv, o_empty, m_res, m_idx, m_nv, m_empty);
            end
        end
    endtask

    task automatic test_random();
        for (int v = 0; v < 40; v++) begin
            int n;
            bit op;
            n  = ($urandom_range(9) == 0) ? 0 : $urandom_range(1, 37);
            op = 1'($urandom);
            for (int i = 0; i < n + LANES; i++) elems[i] = rand_bf16();
            model(op, n);
            do_vector(op, n, 30, $urandom_range(3));
            n_tests++; if (!o_ok) begin n_fail++; $display("FAIL rand_timeout: got no result expected result (vec %0d)", v); end
            n_tests++; if (o_res !== m_res || o_idx !== m_idx) begin
                n_fail++; $display("FAIL rand_value: got %h@%0d expected %h@%0d (vec %0d op=%b len=%0d)", o_res, o_idx, m_res, m_idx, v, op, n);
            end
            n_tests++; if (o_nv !== m_nv || o_empty !== m_empty) begin
                n_fail++; $display("FAIL rand_flags: got nv=%b empty=%b expected nv=%b empty=%b (vec %0d)", o_nv, o_empty, m_nv, m_empty, v);
            end
            n_tests++; if (o_lat !== ((n == 0) ? 0 : 3) || !o_stable) begin
                n_fail++; $display("FAIL rand_timing: got lat=%0d stable=%b expected lat=%0d stable=1", o_lat, o_stable, (n == 0) ? 0 : 3);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; op_max = 1'b0; len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        test_reset();
        test_min_basic();
        test_specials();
        test_empty();
        test_stall_ties();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
